// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS instruction-fetch stage with IF/ID register and one-entry skid buffer
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic        valid_out,
   output logic [31:0] pc_out,
   output logic [31:0] instr_out,
   output logic [5:0]  op
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] drain_addr, drain_addr_nxt;
   logic        ifid_valid, ifid_valid_nxt;
   logic [31:0] ifid_pc, ifid_pc_nxt;
   logic [31:0] ifid_instr, ifid_instr_nxt;
   logic        skid_valid, skid_valid_nxt;
   logic [31:0] skid_pc, skid_pc_nxt;
   logic [31:0] skid_instr, skid_instr_nxt;

   logic        redirect;
   logic [31:0] target_raw;
   logic [31:0] target;

   // Redirect selection: branch wins over jump, target forced word aligned.
   always_comb begin
      redirect   = branch_taken | jump;
      target_raw = branch_taken ? branch_target : jump_target;
      target     = {target_raw[31:2], 2'b00};
   end

   // State and datapath registers; reset abandons any outstanding request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         drain_addr <= 32'h0;
         ifid_valid <= 1'b0;
         ifid_pc    <= 32'h0;
         ifid_instr <= 32'h0;
         skid_valid <= 1'b0;
         skid_pc    <= 32'h0;
         skid_instr <= 32'h0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         drain_addr <= drain_addr_nxt;
         ifid_valid <= ifid_valid_nxt;
         ifid_pc    <= ifid_pc_nxt;
         ifid_instr <= ifid_instr_nxt;
         skid_valid <= skid_valid_nxt;
         skid_pc    <= skid_pc_nxt;
         skid_instr <= skid_instr_nxt;
      end
   end

   // Next-state and memory-port logic; redirect is applied last so it overrides everything.
   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      drain_addr_nxt = drain_addr;
      ifid_valid_nxt = ifid_valid;
      ifid_pc_nxt    = ifid_pc;
      ifid_instr_nxt = ifid_instr;
      skid_valid_nxt = skid_valid;
      skid_pc_nxt    = skid_pc;
      skid_instr_nxt = skid_instr;
      imem_req       = 1'b0;
      imem_addr      = pc;

      case (state)
         FETCH: begin
            imem_req  = 1'b1;
            imem_addr = pc;
            if (redirect) begin
               // An unanswered request must be seen through before refetching.
               if (!imem_ack) begin
                  state_nxt      = DRAIN;
                  drain_addr_nxt = pc;
               end
            end else if (imem_ack) begin
               pc_nxt = pc + 32'd4;
               if (!ifid_valid || !stall) begin
                  ifid_valid_nxt = 1'b1;
                  ifid_pc_nxt    = pc;
                  ifid_instr_nxt = imem_rdata;
               end else begin
                  skid_valid_nxt = 1'b1;
                  skid_pc_nxt    = pc;
                  skid_instr_nxt = imem_rdata;
                  state_nxt      = WAIT;
               end
            end else if (!stall) begin
               // Decode took the current word and nothing new arrived.
               ifid_valid_nxt = 1'b0;
            end
         end
         WAIT: begin
            if (!stall) begin
               ifid_valid_nxt = skid_valid;
               ifid_pc_nxt    = skid_pc;
               ifid_instr_nxt = skid_instr;
               skid_valid_nxt = 1'b0;
               state_nxt      = FETCH;
            end
         end
         DRAIN: begin
            imem_req  = 1'b1;
            imem_addr = drain_addr;
            if (imem_ack) begin
               state_nxt = FETCH;
            end
         end
         default: begin
            state_nxt = FETCH;
         end
      endcase

      if (redirect) begin
         ifid_valid_nxt = 1'b0;
         skid_valid_nxt = 1'b0;
         pc_nxt         = target;
         if (state == WAIT) begin
            state_nxt = FETCH;
         end
      end
   end

   // IF/ID outputs; op is the raw opcode field, qualified downstream by valid_out.
   always_comb begin
      valid_out = ifid_valid;
      pc_out    = ifid_pc;
      instr_out = ifid_instr;
      op        = ifid_instr[31:26];
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the MIPS datapath, directly upstream of the main control decoder. It holds the program counter, drives a request/acknowledge instruction-memory port, and presents the fetched word with its PC and 6-bit opcode field in an IF/ID register. It absorbs downstream stalls through a one-entry skid buffer and redirects on taken branches and jumps resolved downstream.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  32  byte address of the request; stable while imem_req is high.
- imem_ack  in  1  memory accepted the request and imem_rdata is valid this cycle.
- imem_rdata  in  32  instruction word.
- stall  in  1  decode cannot accept; IF/ID must hold.
- branch_taken  in  1  redirect to branch_target this cycle.
- branch_target  in  32  branch destination.
- jump  in  1  redirect to jump_target this cycle.
- jump_target  in  32  jump destination.
- valid_out  out  1  IF/ID holds a live instruction.
- pc_out  out  32  PC of the instruction in IF/ID.
- instr_out  out  32  instruction word in IF/ID.
- op  out  6  instr_out[31:26], feeds the control decoder.

## Operation
- Registers: pc (next fetch address), IF/ID (valid, pc, instr), skid (valid, pc, instr), state.
- States: FETCH, WAIT, DRAIN.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack with no redirect:
  - IF/ID free (valid_out=0 or stall=0): load IF/ID with {1, pc, imem_rdata}; pc <= pc+4; stay in FETCH.
  - IF/ID held (valid_out=1 and stall=1): load skid; pc <= pc+4; go to WAIT.
- WAIT: imem_req=0. When stall=0, IF/ID <= skid, skid invalid, go to FETCH.
- Redirect: redirect = branch_taken | jump; target = branch_taken ? branch_target : jump_target (branch wins if both are set). Target bits [1:0] are forced to 00.
  - Any state: IF/ID valid <= 0; skid valid <= 0; pc <= target. Redirect overrides stall.
  - FETCH with imem_ack the same cycle: the returned data is dropped; the next state is FETCH.
  - FETCH with a request outstanding and no ack: go to DRAIN. imem_req stays high with the old imem_addr to honour the protocol.
  - DRAIN: on imem_ack, drop the data and go to FETCH with the new pc. A second redirect in DRAIN only updates pc.
  - WAIT: go to FETCH.
- While stall=1 and no redirect, IF/ID is unchanged. pc+4 wraps modulo 2^32.
- op is always instr_out[31:26]. Consumers gate op with valid_out.

## Timing
- Reset (asynchronous assert, synchronous-safe release): pc=RESET_PC, state=FETCH, valid_out=0, pc_out=0, instr_out=0, op=0, skid invalid.
  - imem_req is high combinationally in FETCH, so it is 1 during reset and from the first cycle after release.
- imem_ack is sampled on the rising edge. With a zero-wait memory (ack in the same cycle as req), the instruction appears in IF/ID on the next edge.
- Throughput is one instruction per cycle with a zero-wait memory and no stall.
- Redirect latency: target is on imem_addr the cycle after the redirect (FETCH case). In the DRAIN case it appears the cycle after the draining ack.
- Reset asserted mid-request abandons the request immediately; the memory is required to tolerate a dropped req.
- No instruction is lost or duplicated across stall, redirect, or skid transitions.

## Test plan
- Reset release, zero-wait memory returning addr as data, no stall -> imem_addr 0,4,8,12 on consecutive cycles; pc_out/instr_out follow one cycle later; valid_out=1 from the second cycle.
- Stall asserted for 3 cycles while IF/ID holds PC 8 -> IF/ID stays at 8; PC 12 is captured in skid, imem_req drops; on release IF/ID=12, then fetch resumes at 16 with no gap or duplicate.
- branch_taken=1 with target 0x40 while stall=1 -> stall ignored; valid_out=0 next cycle; imem_addr=0x40; next valid_out=1 has pc_out=0x40.
- Memory with 3-cycle ack latency; jump to 0x100 in the first wait cycle -> imem_addr holds the old address until ack; that data is dropped; the next request is 0x100.
- branch_taken and jump together, targets 0x80/0x200 -> fetch at 0x80. Target 0x83 -> fetch at 0x80.
- PC 0xFFFF_FFFC fetched -> next imem_addr 0x0000_0000. rst_n pulsed low mid-DRAIN -> all outputs return to reset values asynchronously and fetch restarts at RESET_PC.
